draw_arbiter: RTL

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arb_pkg.sv | 19 +
 rtl/draw_arbiter_rr_pick.sv | 31 +++
 rtl/draw_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the draw arbiter: FSM state encoding,
// default sizing and the fixed requester index map.
package draw_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

   localparam int DEF_NREQ    = 4;
   localparam int DEF_TIMEOUT = 1023;

   localparam int REQ_BG    = 0;
   localparam int REQ_WALL  = 1;
   localparam int REQ_BIRD  = 2;
   localparam int REQ_SCORE = 3;

endpackage

// File: rtl/draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping to 0; returns the one-hot winner and its encoded index.
module rr_pick import draw_arb_pkg::*; #(
   parameter int NREQ = DEF_NREQ,
   parameter int PW   = $clog2(DEF_NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] win_o,
   output logic [PW-1:0]   idx_o
);

   logic found;
   int   j;

   always_comb begin
      win_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(ptr_i) + i) % NREQ;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            win_o[j] = 1'b1;
            idx_o    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin owner arbiter for the plot datapath (IDLE -> DRAW -> GAP).
// Optional DRAW watchdog enabled by defining DRAW_TIMEOUT_EN.
module draw_arbiter import draw_arb_pkg::*; #(
   parameter int NREQ    = DEF_NREQ,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic                    done,
   input  logic                    hold,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] sel,
   output logic                    plot_en,
   output logic                    busy
`ifdef DRAW_TIMEOUT_EN
   ,
   output logic                    timeout_err
`endif
);

   localparam int PW = $clog2(NREQ);

   arb_state_e      state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [PW-1:0]   sel_q, sel_d;
   logic            plot_q, plot_d;
   logic            busy_q, busy_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] win;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   ptr_nxt;
   logic            to_hit;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req_i (req),
      .ptr_i (ptr_q),
      .win_o (win),
      .idx_o (win_idx)
   );

   // Pointer moves just past the owner being released.
   assign ptr_nxt = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + PW'(1);

`ifdef DRAW_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          terr_q, terr_d;

   assign to_hit      = (cnt_q == CW'(TIMEOUT - 1));
   assign timeout_err = terr_q;
`else
   logic unused_timeout;

   assign to_hit         = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      plot_d  = plot_q;
      busy_d  = busy_q;
      ptr_d   = ptr_q;
`ifdef DRAW_TIMEOUT_EN
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|req && !hold) begin
               state_d = DRAW;
               grant_d = win;
               sel_d   = win_idx;
               plot_d  = 1'b1;
               busy_d  = 1'b1;
`ifdef DRAW_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
         end
         DRAW: begin
`ifdef DRAW_TIMEOUT_EN
            cnt_d = cnt_q + CW'(1);
`endif
            if (done || to_hit) begin
               state_d = GAP;
               grant_d = '0;
               plot_d  = 1'b0;
               ptr_d   = ptr_nxt;
`ifdef DRAW_TIMEOUT_EN
               terr_d  = !done;
`endif
            end
         end
         GAP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            plot_d  = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         plot_q  <= 1'b0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
`ifdef DRAW_TIMEOUT_EN
         cnt_q   <= '0;
         terr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         plot_q  <= plot_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
`ifdef DRAW_TIMEOUT_EN
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
`endif
      end
   end

   assign grant   = grant_q;
   assign sel     = sel_q;
   assign plot_en = plot_q;
   assign busy    = busy_q;

endmodule
